driver_teclado_encoding_n: RTL and testbench
============================================

Name: driver_teclado_encoding_n

Overview:
Parametrised successor to the combinational membrane-keypad encoder: N active-low button lines in, one-hot-low detection, debounced index and press-event out.
- Adds input synchronisation, a debounce FSM, a single-cycle press strobe, a multi-key flag, and a held (non-tristate) index.
- Sits between keypad pins and control logic. It keeps the legacy hab_out meaning: 1 = no valid key.

Parameters:
- N_KEYS, 4, number of button lines (>=2).
- IDX_W, 2, index width; must satisfy 2**IDX_W >= N_KEYS.
- DEB_CYCLES, 16, consecutive stable cycles required for press and release (>=2).
- REPEAT_DELAY, 64, cycles held before first auto-repeat strobe (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 16, cycles between auto-repeat strobes (AUTOREPEAT_EN only).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- b  input  N_KEYS  button lines, active-low, asynchronous to clk.
- index_out  output  IDX_W  index of last debounced key; holds value, never Z.
- hab_out  output  1  1 = no debounced key held; 0 = key held.
- key_valid  output  1  one-cycle strobe on each accepted press.
- multi_out  output  1  1 while synchronised input has more than one line low.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - Synchroniser flops all ones.
  - FSM in IDLE, counters 0.
  - index_out=0, hab_out=1, key_valid=0, multi_out=0.
  - rst asserted mid-operation aborts any state at the next edge and restores these values.
- Synchroniser: 2-flop per line. Edge 0 samples the pin, edge 1 presents it as sync[].
- Decode (combinational on sync[]):
  - single = exactly one bit low; cand = position of that bit.
  - none = all high.
  - multi = two or more low. Multi is treated as "no valid key" for FSM purposes.
- multi_out: registered copy of multi.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
  - IDLE: if single, latch cand into cand_r, cnt<=0, go to DEBOUNCE. Else stay.
  - DEBOUNCE:
    - If single && cand==cand_r: cnt++.
    - When cnt==DEB_CYCLES-1 and the condition still holds: go to HELD, index_out<=cand_r, hab_out<=0, key_valid<=1 for one cycle.
    - Any other pattern (release, different key, multi): go to IDLE, no strobe, outputs unchanged.
  - HELD: stay while single && cand==cand_r. Any change goes to RELEASE with cnt<=0.
  - RELEASE:
    - While none: cnt++. When cnt==DEB_CYCLES-1: go to IDLE, hab_out<=1.
    - Any low line: cnt<=0, stay in RELEASE.
    - A second key cannot be accepted until a full release debounce completes.
- Latency: with a clean press stable from edge 0, key_valid is high in the cycle after edge DEB_CYCLES+2. Release likewise: hab_out rises after edge DEB_CYCLES+2 from the first all-high sample.
- Glitches: a low pulse shorter than DEB_CYCLES+1 synchronised cycles produces no strobe.
- index_out: never changes except on acceptance; it retains the last key after release.
- Counter width: clog2(max(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1). The counter saturates and never wraps.

Optional Feature:
Macro: DRIVER_TECLADO_AUTOREPEAT_EN
- Defined: in HELD, a second counter starts at acceptance.
  - key_valid pulses again REPEAT_DELAY cycles after the acceptance strobe.
  - It then pulses every REPEAT_PERIOD cycles while the same key stays held.
  - Leaving HELD clears the repeat counter immediately; no strobe is issued on that edge.
- Not defined: exactly one key_valid per press. REPEAT_* parameters are unused and no repeat logic is synthesised.

Test Plan (N_KEYS=4, IDX_W=2, DEB_CYCLES=4 unless noted):
1. Reset: assert rst 2 cycles with b=4'b0111 -> index_out=0, hab_out=1, key_valid=0, multi_out=0; FSM IDLE after release of rst.
2. Clean press: b=4'b1011 from edge 0 for 20 cycles -> key_valid=1 exactly once, in the cycle after edge 6; index_out=2'b10; hab_out=0 from the same cycle.
3. Glitch: b=4'b1110 for 3 cycles then 4'b1111 -> no key_valid; hab_out stays 1; index_out unchanged.
4. Multi-key: b=4'b1100 for 10 cycles -> multi_out=1 after edge 2, no key_valid, hab_out=1. Then b=4'b1101 stable -> key_valid, index_out=2'b01.
5. Release bounce: hold key 3, then toggle b between 4'b1111 and 4'b0111 every 2 cycles, then settle high -> no second strobe; hab_out rises only 4 stable-high cycles after settling; index_out stays 2'b11.
6. With DRIVER_TECLADO_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4: hold key 0 for 30 cycles -> strobes at acceptance, then +8, +12, +16, ...; rst mid-hold -> no further strobes, outputs at reset values.

Source files
------------

// File: rtl/driver_teclado_encoding_n.sv
// Debounced N-line active-low keypad encoder: 2-flop synchroniser, one-hot-low decode, press FSM, held index.
// Optional auto-repeat of the press strobe while a key is held, enabled by DRIVER_TECLADO_AUTOREPEAT_EN.
module driver_teclado_encoding_n #(
    parameter int N_KEYS        = 4,
    parameter int IDX_W         = 2,
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] b,
    output logic [IDX_W-1:0]  index_out,
    output logic              hab_out,
    output logic              key_valid,
    output logic              multi_out
);

    localparam int MAX_A   = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t            state, state_nxt;
    logic [N_KEYS-1:0] sync1, sync2;
    logic [N_KEYS-1:0] low;
    logic              none, single, multi, same;
    logic [IDX_W-1:0]  cand, cand_r, cand_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]  index_nxt;
    logic              hab_nxt, kv_nxt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_TOP) ? c : c + CW'(1);
    endfunction

    // A set bit in low means the line is pressed; single uses the clear-lowest-bit trick.
    assign low    = ~sync2;
    assign none   = (low == '0);
    assign single = !none && ((low & (low - N_KEYS'(1))) == '0);
    assign multi  = !none && !single;
    assign same   = single && (cand == cand_r);

    always_comb begin
        cand = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (low[i]) cand = IDX_W'(i);
        end
    end

`ifdef DRIVER_TECLADO_AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0] rcnt, rcnt_nxt;
    logic          rep_on, rep_on_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand_r;
        index_nxt = index_out;
        hab_nxt   = hab_out;
        kv_nxt    = 1'b0;
`ifdef DRIVER_TECLADO_AUTOREPEAT_EN
        rcnt_nxt   = rcnt;
        rep_on_nxt = rep_on;
`endif
        case (state)
            IDLE: begin
                if (single) begin
                    cand_nxt  = cand;
                    cnt_nxt   = '0;
                    state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (same) begin
                    if (cnt == DEB_LAST) begin
                        state_nxt = HELD;
                        index_nxt = cand_r;
                        hab_nxt   = 1'b0;
                        kv_nxt    = 1'b1;
`ifdef DRIVER_TECLADO_AUTOREPEAT_EN
                        rcnt_nxt   = '0;
                        rep_on_nxt = 1'b0;
`endif
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            HELD: begin
                if (!same) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
`ifdef DRIVER_TECLADO_AUTOREPEAT_EN
                    rcnt_nxt   = '0;
                    rep_on_nxt = 1'b0;
                end else if (rcnt == (rep_on ? RP_LAST : RD_LAST)) begin
                    kv_nxt     = 1'b1;
                    rcnt_nxt   = '0;
                    rep_on_nxt = 1'b1;
                end else begin
                    rcnt_nxt = sat_inc(rcnt);
`endif
                end
            end
            RELEASE: begin
                // Any low line restarts the release window, so no new key sneaks in early.
                if (none) begin
                    if (cnt == DEB_LAST) begin
                        state_nxt = IDLE;
                        hab_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '1;
            sync2     <= '1;
            state     <= IDLE;
            cnt       <= '0;
            cand_r    <= '0;
            index_out <= '0;
            hab_out   <= 1'b1;
            key_valid <= 1'b0;
            multi_out <= 1'b0;
`ifdef DRIVER_TECLADO_AUTOREPEAT_EN
            rcnt      <= '0;
            rep_on    <= 1'b0;
`endif
        end else begin
            sync1     <= b;
            sync2     <= sync1;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cand_r    <= cand_nxt;
            index_out <= index_nxt;
            hab_out   <= hab_nxt;
            key_valid <= kv_nxt;
            multi_out <= multi;
`ifdef DRIVER_TECLADO_AUTOREPEAT_EN
            rcnt      <= rcnt_nxt;
            rep_on    <= rep_on_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_driver_teclado_encoding_n.sv
// Directed bench for driver_teclado_encoding_n with DEB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
module tb_driver_teclado_encoding_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] b;
    logic [1:0] index_out;
    logic       hab_out, key_valid, multi_out;

    int n_tests = 0;
    int n_fail  = 0;
    int kv_cnt  = 0;

    driver_teclado_encoding_n #(
        .N_KEYS(4), .IDX_W(2), .DEB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk), .rst(rst), .b(b), .index_out(index_out),
        .hab_out(hab_out), .key_valid(key_valid), .multi_out(multi_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (key_valid === 1'b1) kv_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic rep_exp;
        // Reset with a key already pressed on the pins.
        rst = 1'b1;
        b   = 4'b0111;
        tick();
        tick();
        chk("rst_index", 32'(index_out), 32'd0);
        chk("rst_hab",   32'(hab_out),   32'd1);
        chk("rst_kv",    32'(key_valid), 32'd0);
        chk("rst_multi", 32'(multi_out), 32'd0);
        rst = 1'b0;
        b   = 4'b1111;
        kv_cnt = 0;
        run(8);
        chk("idle_kv_cnt", 32'(kv_cnt),  32'd0);
        chk("idle_hab",    32'(hab_out), 32'd1);

        // Clean press of key 2: strobe after edge 6.
        b = 4'b1011;
        repeat (6) tick();
        chk("press_kv_early",  32'(key_valid), 32'd0);
        chk("press_hab_early", 32'(hab_out),   32'd1);
        tick();
        chk("press_kv",    32'(key_valid), 32'd1);
        chk("press_index", 32'(index_out), 32'd2);
        chk("press_hab",   32'(hab_out),   32'd0);
        tick();
        chk("press_kv_off", 32'(key_valid), 32'd0);
        kv_cnt = 0;
        run(12);
        chk("press_once", 32'(kv_cnt), 32'd0);
        b = 4'b1111;
        repeat (6) tick();
        chk("rel_hab_early", 32'(hab_out), 32'd0);
        tick();
        chk("rel_hab",   32'(hab_out),   32'd1);
        chk("rel_index", 32'(index_out), 32'd2);

        // Short glitch on key 0.
        kv_cnt = 0;
        b = 4'b1110;
        run(3);
        b = 4'b1111;
        run(12);
        chk("glitch_kv_cnt", 32'(kv_cnt),    32'd0);
        chk("glitch_hab",    32'(hab_out),   32'd1);
        chk("glitch_index",  32'(index_out), 32'd2);

        // Two keys together, then a single key 1.
        kv_cnt = 0;
        b = 4'b1100;
        run(2);
        chk("multi_early", 32'(multi_out), 32'd0);
        run(1);
        chk("multi_set", 32'(multi_out), 32'd1);
        run(7);
        chk("multi_kv_cnt", 32'(kv_cnt),  32'd0);
        chk("multi_hab",    32'(hab_out), 32'd1);
        b = 4'b1101;
        repeat (6) tick();
        chk("k1_kv_early", 32'(key_valid), 32'd0);
        tick();
        chk("k1_kv",    32'(key_valid), 32'd1);
        chk("k1_index", 32'(index_out), 32'd1);
        chk("k1_multi", 32'(multi_out), 32'd0);
        b = 4'b1111;
        repeat (7) tick();
        chk("k1_rel_hab", 32'(hab_out), 32'd1);

        // Key 3 then a bouncing release.
        b = 4'b0111;
        repeat (7) tick();
        chk("k3_kv",    32'(key_valid), 32'd1);
        chk("k3_index", 32'(index_out), 32'd3);
        repeat (5) tick();
        kv_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            b = 4'b1111;
            run(2);
            b = 4'b0111;
            run(2);
        end
        chk("bounce_kv_cnt", 32'(kv_cnt),  32'd0);
        chk("bounce_hab",    32'(hab_out), 32'd0);
        b = 4'b1111;
        run(5);
        chk("bounce_hab_early", 32'(hab_out), 32'd0);
        run(1);
        chk("bounce_hab_rise", 32'(hab_out),   32'd1);
        chk("bounce_index",    32'(index_out), 32'd3);
        chk("bounce_no_strobe", 32'(kv_cnt),   32'd0);

        // Hold key 0 for 30 cycles; repeats only in the auto-repeat build.
        b = 4'b1110;
        repeat (7) tick();
        chk("k0_kv",    32'(key_valid), 32'd1);
        chk("k0_index", 32'(index_out), 32'd0);
        for (int k = 1; k <= 23; k++) begin
            tick();
`ifdef DRIVER_TECLADO_AUTOREPEAT_EN
            rep_exp = (k == 8) || (k == 12) || (k == 16) || (k == 20);
`else
            rep_exp = 1'b0;
`endif
            chk($sformatf("hold_kv_%0d", k), 32'(key_valid), 32'(rep_exp));
        end
        chk("hold_hab", 32'(hab_out), 32'd0);

        // Reset in the middle of the hold.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rst_kv", 32'(key_valid), 32'd0);
        end
        chk("mid_rst_index", 32'(index_out), 32'd0);
        chk("mid_rst_hab",   32'(hab_out),   32'd1);
        chk("mid_rst_multi", 32'(multi_out), 32'd0);
        rst = 1'b0;
        b   = 4'b1111;
        kv_cnt = 0;
        run(10);
        chk("post_rst_kv_cnt", 32'(kv_cnt),  32'd0);
        chk("post_rst_hab",    32'(hab_out), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
